// File: rtl/shift_pkg.sv
// Shared encodings for the shift arbiter: shift-op codes and result-source tags.
package shift_pkg;

  localparam logic [1:0] FN_SLL = 2'b00;
  localparam logic [1:0] FN_ROL = 2'b01;
  localparam logic [1:0] FN_SRL = 2'b10;
  localparam logic [1:0] FN_SRA = 2'b11;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/shift_core.sv
// Purely combinational shifter: SLL / ROL / SRL / SRA by n bits (n < WIDTH).
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic [1:0]       funct,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   n,
  output logic [WIDTH-1:0] result
);

  // Rotate-left: shift a doubled copy and take the upper half.
  logic [2*WIDTH-1:0] rot_s;

  assign rot_s = {data, data} << n;

  // Op select.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (funct)
      FN_SLL:  result = data << n;
      FN_ROL:  result = rot_s[2*WIDTH-1:WIDTH];
      FN_SRL:  result = data >> n;
      FN_SRA:  result = $unsigned($signed(data) >>> n);
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between requesters A and B,
// with a single registered result stage that supports backpressure.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       a_funct,
  input  logic [WIDTH-1:0] a_data,
  input  logic [SHW-1:0]   a_n,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_funct,
  input  logic [WIDTH-1:0] b_data,
  input  logic [SHW-1:0]   b_n,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_src
);

  logic             res_valid_r;
  logic [WIDTH-1:0] res_data_r;
  logic             res_src_r;
  logic             last_grant_r;

  logic             can_accept_s;
  logic             grant_a_s;
  logic             grant_b_s;
  logic             accept_s;
  logic [1:0]       sel_funct_s;
  logic [WIDTH-1:0] sel_data_s;
  logic [SHW-1:0]   sel_n_s;
  logic [WIDTH-1:0] shift_result_s;

  // The stage can take a new request when empty or when the held result drains now.
  assign can_accept_s = !res_valid_r || res_ready;

  // Round-robin grant: on contention the requester that did not win last time goes.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (a_valid && b_valid) begin
      grant_a_s = (last_grant_r == SRC_B);
      grant_b_s = (last_grant_r == SRC_A);
    end else begin
      grant_a_s = a_valid;
      grant_b_s = b_valid;
    end
  end

  assign a_ready  = can_accept_s && grant_a_s;
  assign b_ready  = can_accept_s && grant_b_s;
  assign accept_s = a_ready || b_ready;

  // Operand mux ahead of the single shared shifter.
  always_comb begin
    sel_funct_s = a_funct;
    sel_data_s  = a_data;
    sel_n_s     = a_n;
    if (grant_b_s) begin
      sel_funct_s = b_funct;
      sel_data_s  = b_data;
      sel_n_s     = b_n;
    end else begin
      sel_funct_s = a_funct;
      sel_data_s  = a_data;
      sel_n_s     = a_n;
    end
  end

  shift_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift_core (
    .funct  (sel_funct_s),
    .data   (sel_data_s),
    .n      (sel_n_s),
    .result (shift_result_s)
  );

  // Result stage and round-robin history; history moves only on a real accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r  <= 1'b0;
      res_data_r   <= {WIDTH{1'b0}};
      res_src_r    <= SRC_A;
      last_grant_r <= SRC_B;
    end else if (accept_s) begin
      res_valid_r  <= 1'b1;
      res_data_r   <= shift_result_s;
      res_src_r    <= grant_b_s ? SRC_B : SRC_A;
      last_grant_r <= grant_b_s ? SRC_B : SRC_A;
    end else if (res_valid_r && res_ready) begin
      res_valid_r  <= 1'b0;
    end else begin
      res_valid_r  <= res_valid_r;
    end
  end

  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_src   = res_src_r;

endmodule
